// File: rtl/edge_post_proc_pkg.sv
// rtl/edge_post_proc_pkg.sv - shared types and helpers for the edge post-processing stage
package edge_pp_pkg;

  typedef logic [11:0] pixel_t;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  localparam pixel_t PIX_BLACK = 12'h000;

  // Skid buffer word: {sop, eop, data}
  typedef struct packed {
    logic   sop;
    logic   eop;
    pixel_t data;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  function automatic int cnt_width(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/edge_post_proc_if.sv
// rtl/edge_post_proc_if.sv - Avalon-ST style pixel stream with master/slave views
interface edge_post_proc_if;
  import edge_pp_pkg::*;

  logic   valid;
  logic   ready;
  logic   startofpacket;
  logic   endofpacket;
  pixel_t data;

  modport master (output valid, output startofpacket, output endofpacket, output data,
                  input ready);
  modport slave  (input valid, input startofpacket, input endofpacket, input data,
                  output ready);

endinterface

// File: rtl/edge_post_proc_skid.sv
// rtl/edge_post_proc_skid.sv - st_skid_buffer: 2-entry stream buffer with registered ready
module st_skid_buffer #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [1:0]       w_count_nxt;
  logic             r_ready;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_valid && r_ready;
  assign w_pop  = (r_count != 2'd0) && i_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Ready is computed from the next occupancy so it never depends on i_ready combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/edge_post_proc.sv
// rtl/edge_post_proc.sv - border masking, edge recolouring and frame checking of an edge map
// Per-frame edge counting is built only when EDGE_STATS_EN is defined.
module edge_post_proc
  import edge_pp_pkg::*;
#(
  parameter int     IMG_W       = 320,
  parameter int     IMG_H       = 240,
  parameter int     BORDER      = 2,
  parameter pixel_t EDGE_COLOUR = 12'h0F0
) (
  input  logic                                clk,
  input  logic                                reset,
  edge_post_proc_if.slave                     i_up,
  edge_post_proc_if.master                    o_dn,
  output logic [cnt_width(IMG_W, IMG_H)-1:0]  edge_count,
  output logic                                count_valid,
  output logic                                frame_err
);

  localparam int CNT_W = cnt_width(IMG_W, IMG_H);
  localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [X_W-1:0] X_LAST   = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(IMG_H - 1);
  localparam logic [X_W-1:0] X_BORDER = X_W'(BORDER);
  localparam logic [Y_W-1:0] Y_BORDER = Y_W'(BORDER);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] w_px;
  logic [Y_W-1:0] w_py;
  logic           w_ready;
  logic           w_xfer;
  logic           w_emit;
  logic           w_last;
  logic           w_masked;
  logic           w_edge;
  logic           w_end;
  logic           w_err;
  logic           r_err;
  beat_t          w_beat;
  beat_t          w_out;

  assign w_xfer     = i_up.valid && w_ready;
  assign i_up.ready = w_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WAIT_SOP;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_end)       w_state_nxt = WAIT_SOP;
    else if (w_emit) w_state_nxt = ACTIVE;
  end

  // An SOP beat is always pixel (0,0) of a fresh frame, whatever state we were in
  always_comb begin
    w_px = i_up.startofpacket ? '0 : r_x;
    w_py = i_up.startofpacket ? '0 : r_y;
    w_emit      = w_xfer && (r_state == ACTIVE || i_up.startofpacket);
    w_last      = (w_px == X_LAST) && (w_py == Y_LAST);
    w_masked    = (w_px < X_BORDER) || (w_py < Y_BORDER);
    w_edge      = (i_up.data != PIX_BLACK) && !w_masked;
    w_end       = w_emit && (i_up.endofpacket || w_last);
    w_err       = w_emit && ((r_state == ACTIVE && i_up.startofpacket) ||
                             (i_up.endofpacket != w_last));
    w_beat.sop  = i_up.startofpacket;
    w_beat.eop  = i_up.endofpacket || w_last;
    w_beat.data = w_edge ? EDGE_COLOUR : PIX_BLACK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_emit) begin
        if (w_px == X_LAST) begin
          r_x <= '0;
          r_y <= w_py + Y_W'(1);
        end else begin
          r_x <= w_px + X_W'(1);
          r_y <= w_py;
        end
      end
    end
  end

  assign frame_err = r_err;

`ifdef EDGE_STATS_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_edge_count;
  logic             r_count_valid;

  always_comb begin
    w_cnt_base = i_up.startofpacket ? '0 : r_cnt;
    w_cnt_nxt  = w_cnt_base;
    if (w_edge && (w_cnt_base != '1)) w_cnt_nxt = w_cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_edge_count  <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= w_end;
      if (w_emit) r_cnt        <= w_cnt_nxt;
      if (w_end)  r_edge_count <= w_cnt_nxt;
    end
  end

  assign edge_count  = r_edge_count;
  assign count_valid = r_count_valid;
`else
  assign edge_count  = '0;
  assign count_valid = 1'b0;
`endif

  st_skid_buffer #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_emit),
    .i_data  (w_beat),
    .o_ready (w_ready),
    .o_valid (o_dn.valid),
    .o_data  (w_out),
    .i_ready (o_dn.ready)
  );

  assign o_dn.startofpacket = w_out.sop;
  assign o_dn.endofpacket   = w_out.eop;
  assign o_dn.data          = w_out.data;

endmodule
